pipeline_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage core.
- Drives pc_en plus the en/flush pair of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Resolves four hazard sources: data-memory wait states, multi-cycle multiply/divide, taken branches/jumps in EX, and load-use dependencies.
- Owns a small FSM for the multi-cycle conditions; all other decisions are same-cycle combinational.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 16 +
 rtl/pipeline_hazard_ctrl_if.sv | 60 ++++++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_pkg: shared definitions for the 5-stage core hazard controller.
//   ctrl_state_e   : sequencer states (RUN, MEM_WAIT, MD_BUSY; 3 unused)
//   REG_ADDR_W     : register index width
//   MD_TIMEOUT_DEF : default mul/div watchdog limit in MD_BUSY cycles
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned MD_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_BUSY  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard sources into, and stall/flush controls out
// of, the central hazard sequencer.
//   master : the sequencer (consumes hazard inputs, drives enables/flushes)
//   slave  : the pipeline side (drives hazard inputs, consumes controls)
// Optional macro PIPE_HAZARD_PERF_CNT_EN adds perf_stall_cycles and
// perf_flush_count.
interface pipeline_hazard_ctrl_if;
  import pipeline_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic                  ex_wb_load;
  logic [REG_ADDR_W-1:0] ex_wb_rd;
  logic                  ex_branch_taken;
  logic                  ex_md_start;
  logic                  md_done;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  pc_en;
  logic                  if_id_en;
  logic                  if_id_flush;
  logic                  id_ex_en;
  logic                  id_ex_flush;
  logic                  ex_mem_en;
  logic                  ex_mem_flush;
  logic                  mem_wb_en;
  logic                  mem_wb_flush;
  logic                  md_timeout_err;
  logic [1:0]            ctrl_state;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0]           perf_stall_cycles;
  logic [31:0]           perf_flush_count;
`endif

  modport master (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_wb_load, ex_wb_rd,
           ex_branch_taken, ex_md_start, md_done, mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush,
`ifdef PIPE_HAZARD_PERF_CNT_EN
           perf_stall_cycles, perf_flush_count,
`endif
           md_timeout_err, ctrl_state
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_wb_load, ex_wb_rd,
           ex_branch_taken, ex_md_start, md_done, mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush,
`ifdef PIPE_HAZARD_PERF_CNT_EN
           perf_stall_cycles, perf_flush_count,
`endif
           md_timeout_err, ctrl_state
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: combinational load-use hazard comparator.
//   Inputs : ID source indices and use flags, EX load flag and destination.
//   Output : hazard - ID needs a register the EX load has not produced yet.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_wb_load,
  input  logic [REG_ADDR_W-1:0] ex_wb_rd,
  output logic                  hazard
);

  always_comb begin
    hazard = 1'b0;
    // x0 is hardwired zero, so a load into it never creates a dependency.
    if (ex_wb_load && (ex_wb_rd != '0)) begin
      hazard = (id_uses_rs1 && (id_rs1 == ex_wb_rd)) ||
               (id_uses_rs2 && (id_rs2 == ex_wb_rd));
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush sequencer for the 5-stage core.
//   clk, rst_n : core clock, asynchronous active-low reset
//   hz         : pipeline_hazard_ctrl_if.master - hazard sources in;
//                pc_en and en/flush per pipeline register out, sticky
//                md_timeout_err, ctrl_state debug view.
// Priority: memory wait > mul/div busy > taken branch > load-use.
// Optional macro PIPE_HAZARD_PERF_CNT_EN adds stall/flush perf counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.master hz
);

  localparam int unsigned           CNT_W   = $clog2(MD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(MD_TIMEOUT);

  ctrl_state_e      state_q, state_d;
  ctrl_state_e      ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;

  logic mem_wait, lu_hit, md_fin;
  logic st_mem, st_md, do_br, do_lu;
  logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_flush_c;
  logic ex_mem_en_c, ex_mem_flush_c, mem_wb_en_c, mem_wb_flush_c;

  load_use_detect u_lu (
    .id_rs1      (hz.id_rs1),
    .id_rs2      (hz.id_rs2),
    .id_uses_rs1 (hz.id_uses_rs1),
    .id_uses_rs2 (hz.id_uses_rs2),
    .ex_wb_load  (hz.ex_wb_load),
    .ex_wb_rd    (hz.ex_wb_rd),
    .hazard      (lu_hit)
  );

  assign mem_wait = hz.mem_req && !hz.mem_ready;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cnt_inc = cnt_q + CNT_W'(1);
    md_fin  = 1'b0;
    st_mem  = 1'b0;
    st_md   = 1'b0;
    do_br   = 1'b0;
    do_lu   = 1'b0;

    case (state_q)
      MEM_WAIT: begin
        // md_done seen while parked: retarget the exit to RUN now.
        if (hz.md_done && (ret_q == MD_BUSY)) begin
          ret_d = RUN;
          cnt_d = '0;
        end
        if (mem_wait) st_mem  = 1'b1;
        else          state_d = ret_d;
      end
      MD_BUSY: begin
        if (hz.md_done) begin
          md_fin = 1'b1;
          cnt_d  = '0;
        end else if (cnt_inc == CNT_MAX) begin
          md_fin = 1'b1;
          cnt_d  = '0;
          err_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
        if (mem_wait) begin
          st_mem  = 1'b1;
          state_d = MEM_WAIT;
          if (md_fin) ret_d = RUN;
          else        ret_d = MD_BUSY;
        end else begin
          st_md = !hz.md_done;
          if (md_fin) state_d = RUN;
        end
      end
      default: begin
        if (mem_wait) begin
          // A coincident mul/div start is remembered as the return target.
          st_mem  = 1'b1;
          state_d = MEM_WAIT;
          cnt_d   = '0;
          if (hz.ex_md_start) ret_d = MD_BUSY;
          else                ret_d = RUN;
        end else begin
          if (hz.ex_md_start) begin
            state_d = MD_BUSY;
            cnt_d   = '0;
          end
          do_br = hz.ex_branch_taken;
          do_lu = lu_hit && !hz.ex_branch_taken;
        end
      end
    endcase

    pc_en_c        = 1'b1;
    if_id_en_c     = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_en_c     = 1'b1;
    id_ex_flush_c  = 1'b0;
    ex_mem_en_c    = 1'b1;
    ex_mem_flush_c = 1'b0;
    mem_wb_en_c    = 1'b1;
    mem_wb_flush_c = 1'b0;
    if (st_mem) begin
      pc_en_c        = 1'b0;
      if_id_en_c     = 1'b0;
      id_ex_en_c     = 1'b0;
      ex_mem_en_c    = 1'b0;
      mem_wb_en_c    = 1'b0;
      mem_wb_flush_c = 1'b1;
    end else if (st_md) begin
      pc_en_c        = 1'b0;
      if_id_en_c     = 1'b0;
      id_ex_en_c     = 1'b0;
      ex_mem_flush_c = 1'b1;
    end else if (do_br) begin
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
    end else if (do_lu) begin
      pc_en_c        = 1'b0;
      if_id_en_c     = 1'b0;
      id_ex_flush_c  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Controls are gated by rst_n so they drop the instant reset asserts.
  assign hz.pc_en          = rst_n & pc_en_c;
  assign hz.if_id_en       = rst_n & if_id_en_c;
  assign hz.if_id_flush    = rst_n & if_id_flush_c;
  assign hz.id_ex_en       = rst_n & id_ex_en_c;
  assign hz.id_ex_flush    = rst_n & id_ex_flush_c;
  assign hz.ex_mem_en      = rst_n & ex_mem_en_c;
  assign hz.ex_mem_flush   = rst_n & ex_mem_flush_c;
  assign hz.mem_wb_en      = rst_n & mem_wb_en_c;
  assign hz.mem_wb_flush   = rst_n & mem_wb_flush_c;
  assign hz.md_timeout_err = err_q;
  assign hz.ctrl_state     = state_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + ((rst_n && !pc_en_c)  ? 32'd1 : 32'd0);
    perf_flush_d = perf_flush_q + ((rst_n && if_id_flush_c) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  // Same-cycle view: the count includes the event happening this cycle.
  assign hz.perf_stall_cycles = perf_stall_d;
  assign hz.perf_flush_count  = perf_flush_d;
`endif

endmodule
